// File: rtl/spi_sar_adc_responder.sv
// SPI mode-0 slave model of a SAR ADC: samples analog_volts on CS_N fall, resolves one bit per SCLK, shifts result MSB-first.
// Latency: SYNC_STAGES+1 clk from any pin edge to the registered output change.
// Backpressure: none; the SPI controller owns the pace, edges are consumed as they arrive.
module spi_sar_adc_responder #(
   parameter  int DATA_BITS   = 12,
   parameter  int LEAD_ZEROS  = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int FRAME       = LEAD_ZEROS + DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] analog_volts,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic [DATA_BITS-1:0] sample_out,
   output logic [FRAME-1:0]     cmd_word,
   output logic                 frame_done,
   output logic                 frame_error
);

   localparam int CNT_W = $clog2(FRAME + 1);
   localparam int FL_W  = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]     LAST_POS  = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0]     LEAD_POS  = CNT_W'(LEAD_ZEROS);
   localparam logic [FL_W-1:0]      FLUSH_MAX = FL_W'(SYNC_STAGES);
   localparam logic [DATA_BITS-1:0] ONE       = DATA_BITS'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // ---------------------------------------------------------------
   // Pin synchronizers and edge detection
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_prev, cs_prev;
   logic [FL_W-1:0]        flush_cnt;
   logic                   armed;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronizer chains start at idle pin levels; prev holds the sample before last.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   // Arm CS_N fall detection only after the chain holds real pin samples showing CS_N high,
   // so a select already low when reset releases is not mistaken for a new frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt <= '0;
         armed     <= 1'b0;
      end else begin
         if (flush_cnt != FLUSH_MAX)
            flush_cnt <= flush_cnt + FL_W'(1);
         if (flush_cnt == FLUSH_MAX && cs_s)
            armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = armed & cs_prev & ~cs_s;
   assign cs_rise   = cs_s & ~cs_prev;

   // ---------------------------------------------------------------
   // Conversion datapath state
   // ---------------------------------------------------------------
   logic [DATA_BITS-1:0] hold, sar;
   logic [CNT_W-1:0]     bitcnt;
   logic [FRAME-1:0]     rx;
   logic [FRAME-1:0]     rx_nxt;
   logic [CNT_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] trial;
   logic                 bit_val;

   assign rx_nxt  = {rx[FRAME-2:0], mosi_s};
   // On a fall, bitcnt already equals the next bit position q; data bit index is FRAME-1-q.
   assign bit_idx = LAST_POS - bitcnt;
   assign trial   = sar | (ONE << bit_idx);
   assign bit_val = (hold >= trial);

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   logic do_start, do_shift, do_finish, do_eval, do_abort, do_release;

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and per-cycle action strobes; CS_N rise outranks any SCLK edge.
   always_comb begin
      state_nxt  = state;
      do_start   = 1'b0;
      do_shift   = 1'b0;
      do_finish  = 1'b0;
      do_eval    = 1'b0;
      do_abort   = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               do_start  = 1'b1;
               state_nxt = ACQ;
            end
         end
         ACQ, CONV: begin
            if (cs_rise) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               do_shift = 1'b1;
               if (bitcnt == LAST_POS) begin
                  do_finish = 1'b1;
                  state_nxt = DONE;
               end
            end else if (sclk_fall) begin
               do_eval = 1'b1;
               if (bitcnt >= LEAD_POS)
                  state_nxt = CONV;
            end
         end
         DONE: begin
            if (cs_rise) begin
               do_release = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and output registers driven by the FSM strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold        <= '0;
         sar         <= '0;
         bitcnt      <= '0;
         rx          <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         sample_out  <= '0;
         cmd_word    <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         if (do_start) begin
            hold    <= analog_volts;
            sar     <= '0;
            bitcnt  <= '0;
            rx      <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b1;
         end
         if (do_shift) begin
            rx     <= rx_nxt;
            bitcnt <= bitcnt + CNT_W'(1);
            if (do_finish) begin
               sample_out <= sar;
               cmd_word   <= rx_nxt;
               frame_done <= 1'b1;
               miso       <= 1'b0;
            end
         end
         if (do_eval) begin
            if (bitcnt >= LEAD_POS) begin
               if (bit_val)
                  sar <= trial;
               miso <= bit_val;
            end else begin
               miso <= 1'b0;
            end
         end
         if (do_abort || do_release) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            frame_error <= do_abort;
         end
      end
   end

endmodule

// File: tb/tb_spi_sar_adc_responder.sv
// Scoreboard bench: SPI controller driver pushes expected MISO bits and results; monitors pop and compare.
// MISO is checked just before each SCLK rise, results on each frame_done pulse.
// Drives and samples on the falling clk edge, away from the DUT's active edge.
module tb_spi_sar_adc_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] analog_volts;
   logic        sclk, cs_n, mosi;
   logic        miso, miso_oe;
   logic [11:0] sample_out;
   logic [15:0] cmd_word;
   logic        frame_done, frame_error;

   int n_vec = 0;
   int n_miscmp = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   logic        miso_q[$];
   logic [11:0] samp_q[$];
   logic [15:0] cmd_q[$];

   always #5 clk = ~clk;

   spi_sar_adc_responder dut (
      .clk          (clk),
      .reset        (reset),
      .analog_volts (analog_volts),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .mosi         (mosi),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .sample_out   (sample_out),
      .cmd_word     (cmd_word),
      .frame_done   (frame_done),
      .frame_error  (frame_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Result monitor: every frame_done cycle pops one expected sample/command.
   always @(negedge clk) begin
      if (frame_error)
         err_cnt++;
      if (frame_done) begin
         done_cnt++;
         if (samp_q.size() == 0) begin
            check("unexpected_frame_done", 32'd1, 32'd0);
         end else begin
            check("sample_out", {20'd0, sample_out}, {20'd0, samp_q.pop_front()});
            check("cmd_word", {16'd0, cmd_word}, {16'd0, cmd_q.pop_front()});
         end
      end
   end

   // One SPI mode-0 transaction with nrise SCLK pulses.
   task automatic spi_frame(input logic [11:0] v, input logic [15:0] mw, input int nrise,
                            input int chg_at, input logic [11:0] v2, input bit raise_cs);
      logic [15:0] exp_bits;
      exp_bits = {4'b0000, v};
      for (int i = 0; i < nrise; i++)
         miso_q.push_back(exp_bits[15-i]);
      if (nrise == 16) begin
         samp_q.push_back(v);
         cmd_q.push_back(mw);
      end
      @(negedge clk);
      analog_volts = v;
      cs_n = 1'b0;
      for (int i = 0; i < nrise; i++) begin
         mosi = mw[15-i];
         repeat (5) @(negedge clk);
         if (i == 0)
            check("miso_oe_on", {31'd0, miso_oe}, 32'd1);
         check($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, miso_q.pop_front()});
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
         if (i + 1 == chg_at)
            analog_volts = v2;
      end
      repeat (5) @(negedge clk);
      if (raise_cs) begin
         cs_n = 1'b1;
         mosi = 1'b0;
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic full_frame(input logic [11:0] v, input logic [15:0] mw);
      int d0;
      d0 = done_cnt;
      spi_frame(v, mw, 16, -1, 12'd0, 1'b1);
      check("done_pulses", done_cnt - d0, 32'd1);
      check("miso_oe_off", {31'd0, miso_oe}, 32'd0);
   endtask

   initial begin
      int e0, d0;
      reset = 1'b1;
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      analog_volts = '0;
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_oe", {31'd0, miso_oe}, 32'd0);
      check("rst_sample", {20'd0, sample_out}, 32'd0);
      check("rst_cmd", {16'd0, cmd_word}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_err", {31'd0, frame_error}, 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      full_frame(12'd2500, 16'h0000);
      check("sample_2500", {20'd0, sample_out}, 32'h9C4);
      full_frame(12'd1000, 16'h1234);
      full_frame(12'd2000, 16'hFFFF);
      full_frame(12'd3000, 16'h8001);
      check("sample_3000", {20'd0, sample_out}, 32'hBB8);
      full_frame(12'd2500, 16'hA5C3);
      check("cmd_a5c3", {16'd0, cmd_word}, 32'hA5C3);
      full_frame(12'd0, 16'h0F0F);
      full_frame(12'd4095, 16'h5555);
      check("sample_fff", {20'd0, sample_out}, 32'hFFF);

      // Input change mid-frame must not disturb the held value.
      d0 = done_cnt;
      spi_frame(12'd2500, 16'h0000, 16, 6, 12'd100, 1'b1);
      check("held_done", done_cnt - d0, 32'd1);
      check("held_sample", {20'd0, sample_out}, 32'd2500);

      // Early deselect after 8 SCLKs.
      d0 = done_cnt;
      e0 = err_cnt;
      spi_frame(12'd777, 16'hBEEF, 8, -1, 12'd0, 1'b1);
      check("abort_err", err_cnt - e0, 32'd1);
      check("abort_nodone", done_cnt - d0, 32'd0);
      check("abort_sample", {20'd0, sample_out}, 32'd2500);
      check("abort_cmd", {16'd0, cmd_word}, 32'h0000);
      check("abort_oe", {31'd0, miso_oe}, 32'd0);

      // Reset in the middle of a frame, released while CS_N is still low.
      e0 = err_cnt;
      spi_frame(12'd555, 16'h0000, 5, -1, 12'd0, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_sample", {20'd0, sample_out}, 32'd0);
      check("mid_rst_cmd", {16'd0, cmd_word}, 32'd0);
      check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
      check("mid_rst_miso", {31'd0, miso}, 32'd0);
      repeat (10) @(negedge clk);
      check("low_at_release_oe", {31'd0, miso_oe}, 32'd0);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_rst_noerr", err_cnt - e0, 32'd0);
      full_frame(12'd1234, 16'h4321);
      check("sample_1234", {20'd0, sample_out}, 32'd1234);

      repeat (5) @(negedge clk);
      check("total_done", done_cnt, 32'd9);
      check("total_err", err_cnt, 32'd1);
      check("samp_q_empty", samp_q.size(), 32'd0);
      check("miso_q_empty", miso_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
